// File: rtl/main_memory_ctrl_if.sv
// Cache-to-main-memory request/response bundle.
// The cache side drives the request fields; the memory side answers with a block and a ready pulse.
interface main_memory_ctrl_if;
  logic         isLock;
  logic         isMemRead;
  logic [9:0]   address;
  logic [127:0] memWriteData;
  logic [127:0] memReadData;
  logic         memReady;
  logic         busy;

  modport master (
    output isLock, isMemRead, address, memWriteData,
    input  memReadData, memReady, busy
  );

  modport slave (
    input  isLock, isMemRead, address, memWriteData,
    output memReadData, memReady, busy
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Fixed-latency block memory: 64 blocks of four 32-bit words, one request per isLock low/high handshake.
// Storage reinitialises on reset so word index i holds the value i.
module main_memory_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             reset,
  main_memory_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP, WAIT_REL} state_t;

  state_t       stateReg, stateNext;
  logic [3:0]   countReg, countNext;
  logic [5:0]   blockReg;
  logic         isReadReg;
  logic [127:0] wrDataReg;
  logic [127:0] readDataReg;
  logic         memReadyReg;
  logic         accept;
  logic         commit;

  logic [31:0]  mem [256];
  logic [127:0] blockData;

  logic unusedAddrBits;
  assign unusedAddrBits = &{1'b0, bus.address[3:0]};

  // Word 0 of a block sits in the most significant slice of the 128-bit bus.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign blockData[127 - 32*gi -: 32] = mem[{blockReg, 2'(gi)}];
  end

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    accept    = 1'b0;
    commit    = 1'b0;
    case (stateReg)
      IDLE: begin
        if (!bus.isLock) begin
          accept    = 1'b1;
          countNext = 4'(LATENCY - 1);
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (countReg == 4'd0) begin
          commit    = 1'b1;
          stateNext = RESP;
        end else begin
          countNext = countReg - 4'd1;
        end
      end
      RESP:     stateNext = WAIT_REL;
      WAIT_REL: if (bus.isLock) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= IDLE;
      countReg    <= 4'd0;
      blockReg    <= 6'd0;
      isReadReg   <= 1'b0;
      wrDataReg   <= '0;
      readDataReg <= '0;
      memReadyReg <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      countReg    <= countNext;
      memReadyReg <= commit;
      if (accept) begin
        blockReg  <= bus.address[9:4];
        isReadReg <= bus.isMemRead;
        wrDataReg <= bus.memWriteData;
      end
      // A write echoes the block it just stored, which equals the latched data.
      if (commit) readDataReg <= isReadReg ? blockData : wrDataReg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (commit && !isReadReg) begin
      for (int w = 0; w < 4; w++) mem[{blockReg, 2'(w)}] <= wrDataReg[127 - 32*w -: 32];
    end
  end

  assign bus.memReadData = readDataReg;
  assign bus.memReady    = memReadyReg;
  assign bus.busy        = (stateReg != IDLE);
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Bench for main_memory_ctrl: table of requests against a LATENCY=4 instance checked through a
// response scoreboard, plus hand sequences for release, abort, async reset and a LATENCY=1 instance.
module tb_main_memory_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  main_memory_ctrl_if bus ();
  main_memory_ctrl_if bus1 ();

  main_memory_ctrl #(.LATENCY(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
  main_memory_ctrl #(.LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  localparam int LAT = 4;

  typedef struct {
    logic [127:0] data;
    int           due;
  } sb_t;

  typedef struct {
    logic [9:0]   addr;
    logic         rd;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  sb_t  sbQ[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulseCount = 0;

  localparam logic [127:0] DATA_ABCD = 128'hAAAA_0001_BBBB_0002_CCCC_0003_DDDD_0004;
  localparam logic [127:0] DATA_B21  = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;

  function automatic logic [127:0] blk(input int b);
    return {32'(4*b), 32'(4*b + 1), 32'(4*b + 2), 32'(4*b + 3)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Every memReady pulse must match the oldest outstanding request in data and arrival cycle.
  always @(posedge clk) begin
    sb_t item;
    #1;
    if (bus.memReady === 1'b1) begin
      pulseCount++;
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready cycle=%0d data=%h", cyc, bus.memReadData);
      end else begin
        item = sbQ.pop_front();
        if (bus.memReadData !== item.data || cyc != item.due) begin
          errors++;
          $display("FAIL response got data=%h cycle=%0d expected data=%h cycle=%0d",
                   bus.memReadData, cyc, item.data, item.due);
        end else begin
          $display("resp ok cycle=%0d data=%h", cyc, bus.memReadData);
        end
      end
    end
  end

  task automatic check1(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // One full handshake; hold >= 1 keeps isLock low that many extra cycles after the pulse.
  task automatic runReq(input logic [9:0] addr, input logic rd, input logic [127:0] wd,
                        input logic [127:0] exp, input int hold, input bit perturb);
    int  start;
    int  n;
    bit  busyBad;
    @(negedge clk);
    bus.isLock       = 1'b0;
    bus.address      = addr;
    bus.isMemRead    = rd;
    bus.memWriteData = wd;
    sbQ.push_back('{exp, cyc + 1 + LAT});
    start = pulseCount;
    n = 0;
    $display("req addr=%h rd=%0b hold=%0d perturb=%0b", addr, rd, hold, perturb);
    if (perturb) begin
      @(negedge clk);
      n = 1;
      bus.address      = 10'h0F0;
      bus.isMemRead    = 1'b0;
      bus.memWriteData = {4{32'hDEAD_BEEF}};
    end
    while (pulseCount == start && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pulseCount == start) begin
      errors++;
      $display("FAIL ready_timeout got=no_pulse expected=pulse addr=%h", addr);
    end
    busyBad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) busyBad = 1'b1;
    end
    check1("busy_while_locked", 128'(busyBad), 128'd0);
    bus.isLock = 1'b1;
    @(posedge clk);
    #1;
    check1("busy_release", 128'(bus.busy), 128'd0);
    check1("data_hold", bus.memReadData, exp);
  endtask

  initial begin
    int l1Blocks[4];
    int start;
    int n;

    vecs[0] = '{10'h010, 1'b1, 128'h0, blk(1)};
    vecs[1] = '{10'h3F0, 1'b0, DATA_ABCD, DATA_ABCD};
    vecs[2] = '{10'h3FC, 1'b1, 128'h0, DATA_ABCD};
    vecs[3] = '{10'h3E0, 1'b1, 128'h0, blk(62)};
    vecs[4] = '{10'h000, 1'b1, 128'h0, blk(0)};
    vecs[5] = '{10'h155, 1'b0, DATA_B21, DATA_B21};
    vecs[6] = '{10'h15F, 1'b1, 128'h0, DATA_B21};
    l1Blocks = '{3, 7, 40, 63};

    bus.isLock = 1'b1;  bus.isMemRead = 1'b1;  bus.address = '0;  bus.memWriteData = '0;
    bus1.isLock = 1'b1; bus1.isMemRead = 1'b1; bus1.address = '0; bus1.memWriteData = '0;

    // Reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    check1("reset_ready", 128'(bus.memReady), 128'd0);
    check1("reset_busy", 128'(bus.busy), 128'd0);
    check1("reset_data", bus.memReadData, 128'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 7; i++)
      runReq(vecs[i].addr, vecs[i].rd, vecs[i].wdata, vecs[i].exp, 1, 1'b0);

    // isLock held low long after the response: one pulse only.
    runReq(10'h010, 1'b1, 128'h0, blk(1), 20, 1'b0);

    // Inputs changed after acceptance must not affect the access.
    runReq(10'h000, 1'b1, 128'h0, blk(0), 1, 1'b1);
    runReq(10'h0F0, 1'b1, 128'h0, blk(15), 1, 1'b0);

    // isLock released during BUSY: response still issues, WAIT_REL leaves on the next edge.
    @(negedge clk);
    bus.isLock = 1'b0; bus.address = 10'h050; bus.isMemRead = 1'b1;
    sbQ.push_back('{blk(5), cyc + 1 + LAT});
    $display("req addr=050 early release");
    @(negedge clk);
    bus.isLock = 1'b1;
    start = pulseCount;
    n = 0;
    while (pulseCount == start && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pulseCount == start) begin
      errors++;
      $display("FAIL early_release_timeout got=no_pulse expected=pulse");
    end
    @(posedge clk); #1;
    check1("early_release_wait", 128'(bus.busy), 128'd1);
    @(posedge clk); #1;
    check1("early_release_idle", 128'(bus.busy), 128'd0);

    // Reset two cycles into a write aborts it.
    @(negedge clk);
    bus.isLock = 1'b0; bus.address = 10'h020; bus.isMemRead = 1'b0;
    bus.memWriteData = {4{32'h1234_5678}};
    $display("req addr=020 write aborted by reset");
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    bus.isLock = 1'b1;
    #1;
    check1("abort_busy", 128'(bus.busy), 128'd0);
    check1("abort_ready", 128'(bus.memReady), 128'd0);
    check1("abort_data", bus.memReadData, 128'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    runReq(10'h020, 1'b1, 128'h0, blk(2), 1, 1'b0);

    // LATENCY=1 instance, back-to-back reads with one isLock-high cycle between.
    foreach (l1Blocks[k]) begin
      @(negedge clk);
      bus1.isLock = 1'b0; bus1.isMemRead = 1'b1; bus1.address = {6'(l1Blocks[k]), 4'h0};
      @(posedge clk); #1;
      check1("l1_accept_ready", 128'(bus1.memReady), 128'd0);
      @(posedge clk); #1;
      check1("l1_ready", 128'(bus1.memReady), 128'd1);
      check1("l1_data", bus1.memReadData, blk(l1Blocks[k]));
      $display("l1 req block=%0d data=%h", l1Blocks[k], bus1.memReadData);
      @(posedge clk); #1;
      check1("l1_ready_drop", 128'(bus1.memReady), 128'd0);
      @(negedge clk);
      bus1.isLock = 1'b1;
      @(posedge clk);
    end

    repeat (8) @(posedge clk);
    #2;
    check1("scoreboard_empty", 128'(sbQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
